// File: rtl/sa_gemm_top.sv
// Weight-stationary systolic GEMM row engine.
// Each accepted A row produces one C row: c[j] = sum_k a[k]*B[k][j] + d[j],
// computed modulo 2^WIDTH. B is held in the PE grid and kept across jobs.
// The A elements are skewed into the grid. The bias enters at the top of each
// column as the initial partial sum. The column outputs are deskewed, so a full
// C row appears 2*SIZE unstalled cycles after its A row was accepted.

// Enabled delay line of D >= 1 stages, cleared by reset.
module sa_gemm_dly #(
  parameter int W = 16,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [D-1:0][W-1:0] sr_q, sr_d;

  // Shift-in next value; stage 0 takes the input.
  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = din;
    for (int i = 1; i < D; i++) sr_d[i] = sr_q[i-1];
  end

  // Stages hold whenever the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst)     sr_q <= '0;
    else if (en) sr_q <= sr_d;
  end

  assign dout = sr_q[D-1];
endmodule

// One processing element: accumulates a*w onto the partial sum from above.
module sa_gemm_pe #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] w_in,
  input  logic [W-1:0] p_in,
  output logic [W-1:0] p_out
);
  logic [W-1:0] p_q, p_d;

  // Truncating multiply-accumulate; wrap is intended.
  always_comb p_d = p_in + a_in * w_in;

  // Partial-sum register, frozen during stall.
  always_ff @(posedge clk) begin
    if (rst)     p_q <= '0;
    else if (en) p_q <= p_d;
  end

  assign p_out = p_q;
endmodule

module sa_gemm_top #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_b_vld,
  input  logic [SIZE-1:0][WIDTH-1:0]  i_b_row,
  output logic                        o_b_rdy,
  input  logic                        i_a_vld,
  input  logic [SIZE-1:0][WIDTH-1:0]  i_a_row,
  input  logic [SIZE-1:0][WIDTH-1:0]  i_d_row,
  input  logic                        i_a_last,
  output logic                        o_a_rdy,
  output logic                        o_c_vld,
  output logic [SIZE-1:0][WIDTH-1:0]  o_c_row,
  output logic                        o_c_last,
  input  logic                        i_c_rdy,
  output logic                        o_busy,
  output logic                        o_b_loaded
);
  localparam int STAGES = 2 * SIZE;
  localparam int CW     = (SIZE <= 4) ? 2 : $clog2(SIZE);
  localparam logic [CW-1:0] LAST_ROW = CW'(SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_B, S_COMPUTE, S_DRAIN} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          b_loaded_q, b_loaded_d;
  logic          busy_q, busy_d;
  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] b_q, b_d;

  logic [STAGES:0] vld_pipe_q, vld_pipe_d;
  logic [STAGES:0] last_pipe_q, last_pipe_d;
  logic [SIZE-1:0][WIDTH-1:0] c_row_q, c_row_d;

  logic stall, en, a_acc, b_acc;
  logic [SIZE-1:0][WIDTH-1:0] a_cap, d_cap;

  // a_h[k][j]: A element seen by PE(k,j); p_v[k][j]: partial sum into PE(k,j).
  logic [WIDTH-1:0] a_h [SIZE][SIZE];
  logic [WIDTH-1:0] p_v [SIZE+1][SIZE];
  logic [WIDTH-1:0] col_dsk [SIZE];

  assign stall = vld_pipe_q[STAGES] && !i_c_rdy;
  assign en    = !stall;

  // Ready generation; B wins over A in IDLE.
  always_comb begin
    o_b_rdy = 1'b0;
    o_a_rdy = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_b_rdy = 1'b1;
        o_a_rdy = b_loaded_q && !i_b_vld;
      end
      S_LOAD_B:  o_b_rdy = 1'b1;
      S_COMPUTE: o_a_rdy = !stall;
      default: ;
    endcase
  end

  assign b_acc = i_b_vld && o_b_rdy;
  assign a_acc = i_a_vld && o_a_rdy;

  // Bubbles enter the grid as zeros; their valid bit stays low.
  always_comb begin
    a_cap = a_acc ? i_a_row : '0;
    d_cap = a_acc ? i_d_row : '0;
  end

  // Next state, row counter, weight writes and load flag.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    b_loaded_d = b_loaded_q;
    b_d        = b_q;
    if (b_acc) begin
      for (int r = 0; r < SIZE; r++)
        if (cnt_q == CW'(r)) b_d[r] = i_b_row;
    end
    case (state_q)
      S_IDLE: begin
        if (b_acc) begin
          b_loaded_d = 1'b0;
          cnt_d      = cnt_q + 1'b1;
          state_d    = S_LOAD_B;
        end else if (a_acc) begin
          state_d = i_a_last ? S_DRAIN : S_COMPUTE;
        end
      end
      S_LOAD_B: begin
        if (b_acc) begin
          if (cnt_q == LAST_ROW) begin
            cnt_d      = '0;
            b_loaded_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_COMPUTE: if (a_acc && i_a_last) state_d = S_DRAIN;
      S_DRAIN:   if (o_c_vld && i_c_rdy && o_c_last) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Control FSM registers with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      b_loaded_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      b_loaded_q <= b_loaded_d;
      busy_q     <= busy_d;
    end
  end

  // Stationary weight storage.
  always_ff @(posedge clk) begin
    if (rst) b_q <= '0;
    else     b_q <= b_d;
  end

  // Valid/last travel alongside the data wavefront.
  always_comb begin
    vld_pipe_d  = {vld_pipe_q[STAGES-1:0], a_acc};
    last_pipe_d = {last_pipe_q[STAGES-1:0], a_acc & i_a_last};
    for (int j = 0; j < SIZE; j++) c_row_d[j] = col_dsk[j];
  end

  // Valid/last shift registers and output row register, all frozen on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      c_row_q     <= '0;
    end else if (en) begin
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      c_row_q     <= c_row_d;
    end
  end

  for (genvar k = 0; k < SIZE; k++) begin : g_row
    // Capture plus k-cycle skew for A element k.
    sa_gemm_dly #(.W(WIDTH), .D(k + 1)) u_a_skew (
      .clk(clk), .rst(rst), .en(en), .din(a_cap[k]), .dout(a_h[k][0])
    );
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      if (j > 0) begin : g_a_fwd
        sa_gemm_dly #(.W(WIDTH), .D(1)) u_a_fwd (
          .clk(clk), .rst(rst), .en(en), .din(a_h[k][j-1]), .dout(a_h[k][j])
        );
      end
      sa_gemm_pe #(.W(WIDTH)) u_pe (
        .clk(clk), .rst(rst), .en(en),
        .a_in(a_h[k][j]), .w_in(b_q[k][j]),
        .p_in(p_v[k][j]), .p_out(p_v[k+1][j])
      );
    end
  end

  for (genvar j = 0; j < SIZE; j++) begin : g_colio
    // Bias seeds the column sum, skewed to meet a[0] at PE(0,j).
    sa_gemm_dly #(.W(WIDTH), .D(j + 1)) u_d_skew (
      .clk(clk), .rst(rst), .en(en), .din(d_cap[j]), .dout(p_v[0][j])
    );
    if (j == SIZE - 1) begin : g_nodsk
      assign col_dsk[j] = p_v[SIZE][j];
    end else begin : g_dsk
      sa_gemm_dly #(.W(WIDTH), .D(SIZE - 1 - j)) u_deskew (
        .clk(clk), .rst(rst), .en(en), .din(p_v[SIZE][j]), .dout(col_dsk[j])
      );
    end
  end

  assign o_c_vld    = vld_pipe_q[STAGES];
  assign o_c_last   = last_pipe_q[STAGES];
  assign o_c_row    = c_row_q;
  assign o_busy     = busy_q;
  assign o_b_loaded = b_loaded_q;
endmodule

// File: tb/tb_sa_gemm_top.sv
// Scoreboard bench for sa_gemm_top (SIZE=4, WIDTH=16) with directed vectors.
module tb_sa_gemm_top;
  localparam int S = 4;
  localparam int W = 16;
  typedef logic [S-1:0][W-1:0] row_t;
  typedef struct {
    row_t row;
    logic last;
    int   acc;
    bit   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic i_b_vld, o_b_rdy, i_a_vld, i_a_last, o_a_rdy;
  logic o_c_vld, o_c_last, i_c_rdy, o_busy, o_b_loaded;
  row_t i_b_row, i_a_row, i_d_row, o_c_row;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_out = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sa_gemm_top #(.WIDTH(W), .SIZE(S)) dut (
    .clk(clk), .rst(rst),
    .i_b_vld(i_b_vld), .i_b_row(i_b_row), .o_b_rdy(o_b_rdy),
    .i_a_vld(i_a_vld), .i_a_row(i_a_row), .i_d_row(i_d_row),
    .i_a_last(i_a_last), .o_a_rdy(o_a_rdy),
    .o_c_vld(o_c_vld), .o_c_row(o_c_row), .o_c_last(o_c_last),
    .i_c_rdy(i_c_rdy), .o_busy(o_busy), .o_b_loaded(o_b_loaded)
  );

  function automatic row_t mk(input int e0, input int e1, input int e2, input int e3);
    row_t r;
    r[0] = e0[15:0];
    r[1] = e1[15:0];
    r[2] = e2[15:0];
    r[3] = e3[15:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: hold-stability during stall, then pop/compare on each consumed row.
  row_t prev_row;
  logic prev_last;
  bit   have_prev = 0;
  exp_t e_mon;
  always @(negedge clk) begin
    if (have_prev) begin
      chk("hold_vld", {63'd0, o_c_vld}, 64'd1);
      chk("hold_row", o_c_row, prev_row);
      chk("hold_last", {63'd0, o_c_last}, {63'd0, prev_last});
    end
    have_prev = o_c_vld && !i_c_rdy && !rst;
    prev_row  = o_c_row;
    prev_last = o_c_last;
    if (o_c_vld && i_c_rdy) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_row actual=%h required=none", o_c_row);
      end else begin
        e_mon = sb.pop_front();
        chk("c_row", o_c_row, e_mon.row);
        chk("c_last", {63'd0, o_c_last}, {63'd0, e_mon.last});
        if (e_mon.lat) chk("latency", 64'(cyc - e_mon.acc), 64'd8);
      end
    end
  end

  task automatic send_a(input row_t a, input row_t d, input logic last,
                        input row_t exp_row, input bit lat);
    exp_t e;
    int n;
    i_a_vld = 1'b1; i_a_row = a; i_d_row = d; i_a_last = last;
    n = 0;
    @(negedge clk);
    while (!o_a_rdy && n < 100) begin @(negedge clk); n++; end
    if (!o_a_rdy) begin
      checks++; errors++;
      $display("FAIL a_accept_timeout actual=not_ready required=ready");
    end else begin
      e.row = exp_row; e.last = last; e.acc = cyc + 1; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    i_a_vld = 1'b0; i_a_last = 1'b0;
  endtask

  task automatic send_b(input row_t r0, input row_t r1, input row_t r2, input row_t r3);
    row_t rs[4];
    int n;
    rs[0] = r0; rs[1] = r1; rs[2] = r2; rs[3] = r3;
    for (int i = 0; i < 4; i++) begin
      i_b_vld = 1'b1; i_b_row = rs[i];
      n = 0;
      @(negedge clk);
      while (!o_b_rdy && n < 100) begin @(negedge clk); n++; end
      if (!o_b_rdy) begin
        checks++; errors++;
        $display("FAIL b_accept_timeout actual=not_ready required=ready");
      end
      @(posedge clk); #1;
      if (i == 0) chk("b_loaded_clr", {63'd0, o_b_loaded}, 64'd0);
    end
    i_b_vld = 1'b0;
    chk("b_loaded_set", {63'd0, o_b_loaded}, 64'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d_left required=0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  row_t a_tab[6];
  row_t x_tab[6];
  row_t z;
  int   n0;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    z = '0;
    rst = 1'b1; i_b_vld = 0; i_b_row = '0; i_a_vld = 0; i_a_row = '0;
    i_d_row = '0; i_a_last = 0; i_c_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_c_vld", {63'd0, o_c_vld}, 64'd0);
    chk("rst_c_row", o_c_row, 64'd0);
    chk("rst_c_last", {63'd0, o_c_last}, 64'd0);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_b_loaded", {63'd0, o_b_loaded}, 64'd0);
    chk("rst_b_rdy", {63'd0, o_b_rdy}, 64'd1);
    chk("rst_a_rdy", {63'd0, o_a_rdy}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity weights, single-row job with latency check.
    send_b(mk(1,0,0,0), mk(0,1,0,0), mk(0,0,1,0), mk(0,0,0,1));
    send_a(mk(1,2,3,4), z, 1'b1, mk(1,2,3,4), 1'b1);
    wait_drain();
    chk("idle_busy", {63'd0, o_busy}, 64'd0);

    // Second job reuses identity weights; bias added, wrap in column 0.
    chk("reuse_a_rdy", {63'd0, o_a_rdy}, 64'd1);
    send_a(mk(5,6,7,8), mk(1,1,1,1), 1'b0, mk(6,7,8,9), 1'b1);
    send_a(mk(16'hFFFF,16'h0100,0,3), mk(1,0,16'h00FF,0), 1'b1,
           mk(0,16'h0100,16'h00FF,3), 1'b1);
    wait_drain();

    // Six back-to-back rows with a 3-cycle consumer stall.
    a_tab[0] = mk(11,12,13,14); x_tab[0] = mk(111,12,13,15);
    a_tab[1] = mk(21,22,23,24); x_tab[1] = mk(121,22,23,25);
    a_tab[2] = mk(31,32,33,34); x_tab[2] = mk(131,32,33,35);
    a_tab[3] = mk(41,42,43,44); x_tab[3] = mk(141,42,43,45);
    a_tab[4] = mk(51,52,53,54); x_tab[4] = mk(151,52,53,55);
    a_tab[5] = mk(61,62,63,64); x_tab[5] = mk(161,62,63,65);
    fork
      begin
        for (int i = 0; i < 6; i++) send_a(a_tab[i], mk(100,0,0,1), 1'b0, x_tab[i], 1'b0);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!o_c_vld && n < 100) begin @(negedge clk); n++; end
        if (!o_c_vld) begin
          checks++; errors++;
          $display("FAIL stall_setup actual=no_output required=output");
        end
        @(posedge clk); #1;
        i_c_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_a_rdy", {63'd0, o_a_rdy}, 64'd0);
          @(posedge clk); #1;
        end
        i_c_rdy = 1'b1;
      end
    join
    send_a(mk(1,1,1,1), z, 1'b1, mk(1,1,1,1), 1'b0);
    wait_drain();

    // Non-symmetric B checks orientation c[j] = sum_k a[k]*B[k][j].
    send_b(mk(1,2,3,4), mk(0,1,0,0), mk(0,0,1,0), mk(0,0,0,1));
    send_a(mk(1,1,1,1), z, 1'b0, mk(1,3,4,5), 1'b1);
    send_a(mk(2,0,0,5), z, 1'b1, mk(2,4,6,13), 1'b1);
    wait_drain();

    // All-2 weights with unit bias.
    send_b(mk(2,2,2,2), mk(2,2,2,2), mk(2,2,2,2), mk(2,2,2,2));
    send_a(mk(1,1,1,1), mk(1,1,1,1), 1'b1, mk(9,9,9,9), 1'b1);
    wait_drain();
    chk("done_busy", {63'd0, o_busy}, 64'd0);
    chk("done_b_rdy", {63'd0, o_b_rdy}, 64'd1);

    // All-1 weights: a bubble between rows, then a wrapping sum.
    send_b(mk(1,1,1,1), mk(1,1,1,1), mk(1,1,1,1), mk(1,1,1,1));
    send_a(mk(1,2,3,4), z, 1'b0, mk(10,10,10,10), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send_a(mk(16'h8000,16'h8000,0,0), z, 1'b1, mk(0,0,0,0), 1'b0);
    wait_drain();

    // Reset with three rows in flight.
    send_a(mk(1,0,0,0), z, 1'b0, mk(1,1,1,1), 1'b0);
    send_a(mk(0,2,0,0), z, 1'b0, mk(2,2,2,2), 1'b0);
    send_a(mk(0,0,3,0), z, 1'b0, mk(3,3,3,3), 1'b0);
    sb.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_c_vld", {63'd0, o_c_vld}, 64'd0);
    chk("mid_rst_b_loaded", {63'd0, o_b_loaded}, 64'd0);
    chk("mid_rst_busy", {63'd0, o_busy}, 64'd0);
    chk("mid_rst_c_row", o_c_row, 64'd0);
    chk("mid_rst_a_rdy", {63'd0, o_a_rdy}, 64'd0);
    rst = 1'b0;
    n0 = n_out;
    repeat (20) @(posedge clk);
    #1;
    chk("no_stale_rows", 64'(n_out - n0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sa_gemm_top.md
SA_GEMM_TOP -- requirements
Module: sa_gemm_top

Interface
REQ-001 Parameter WIDTH, default 16: element width in bits (A, B, D, C).
REQ-002 Parameter SIZE, default 4: array dimension; B is SIZE x SIZE; rows carry SIZE elements; SIZE >= 2.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 i_b_vld  in  1  B row valid.
REQ-006 i_b_row  in  [SIZE][WIDTH]  B row k; element j = B[k][j].
REQ-007 o_b_rdy  out  1  B row accepted when i_b_vld && o_b_rdy.
REQ-008 i_a_vld  in  1  A row valid.
REQ-009 i_a_row  in  [SIZE][WIDTH]  A row; element k = a[k].
REQ-010 i_d_row  in  [SIZE][WIDTH]  bias row, sampled with the A row.
REQ-011 i_a_last  in  1  marks final A row of a job; sampled with the A row.
REQ-012 o_a_rdy  out  1  A row accepted when i_a_vld && o_a_rdy.
REQ-013 o_c_vld  out  1  C row valid.
REQ-014 o_c_row  out  [SIZE][WIDTH]  C row.
REQ-015 o_c_last  out  1  C row corresponds to the A row with i_a_last.
REQ-016 i_c_rdy  in  1  C row consumed when o_c_vld && i_c_rdy.
REQ-017 o_busy  out  1  high in any state other than IDLE.
REQ-018 o_b_loaded  out  1  full B held; cleared only by rst or a new B load.

Function
REQ-019 Compute c[j] = sum over k of a[k]*B[k][j], plus d[j], mod 2^WIDTH (unsigned, wrap; products truncated to WIDTH).
REQ-020 FSM states: IDLE, LOAD_B, COMPUTE, DRAIN.
REQ-021 IDLE: o_b_rdy=1; o_a_rdy=o_b_loaded. Accepted B row -> LOAD_B. Accepted A row -> COMPUTE. B takes priority if both valid; A is then not accepted.
REQ-022 LOAD_B: o_b_rdy=1, o_a_rdy=0. 2-bit..clog2(SIZE) row counter stores rows 0..SIZE-1 in order. o_b_loaded=0 from the first accepted row until row SIZE-1 is stored. Then -> IDLE with o_b_loaded=1.
REQ-023 COMPUTE: o_b_rdy=0; o_a_rdy=!stall; one A row per cycle max. Accepted row with i_a_last=1 -> DRAIN.
REQ-024 DRAIN: o_a_rdy=0, o_b_rdy=0. -> IDLE in the cycle after the o_c_last row is consumed.
REQ-025 Internal input skew: element k delayed k cycles; output deskew: column j delayed SIZE-1-j cycles; d[j] pipelined to align with column j.
REQ-026 Latency: row accepted at edge t appears on o_c_vld/o_c_row at edge t+2*SIZE, counting only non-stalled cycles. C rows keep A order.
REQ-027 stall = o_c_vld && !i_c_rdy. While stalled, every pipeline, skew, deskew and bias register holds. o_c_row/o_c_last stay stable.
REQ-028 Weights persist across jobs. A later job may start from IDLE without reloading B.
REQ-029 Gaps in i_a_vld insert bubbles; no C row is generated for a bubble.
REQ-030 Outputs depend only on registered state. No combinational path from i_c_rdy to o_c_row.

Reset
REQ-031 On rst: FSM=IDLE, all pipeline valid bits=0, B registers=0, counters=0.
REQ-032 On rst, output values: o_c_vld=0, o_c_row=0, o_c_last=0, o_busy=0, o_b_loaded=0, o_b_rdy=1, o_a_rdy=0.
REQ-033 rst mid-operation (any state) discards in-flight rows. No C row from before reset may appear afterwards.

Verification (SIZE=4, WIDTH=16)
REQ-034 Load B=identity, D=0. A row [1,2,3,4] accepted at edge t -> C [1,2,3,4] with o_c_vld at t+8.
REQ-035 Load B all 2, D=[1,1,1,1]. A [1,1,1,1] with last -> C [9,9,9,9], o_c_last=1. FSM returns to IDLE; o_busy=0.
REQ-036 B all 1, A [0x8000,0x8000,0,0] -> C [0,0,0,0] (wrap).
REQ-037 Stream 6 back-to-back rows with i_c_rdy low for 3 cycles mid-stream -> o_a_rdy=0 during stall, output held stable, all 6 rows correct and in order.
REQ-038 Reuse: second job with no B load after REQ-034 -> o_a_rdy=1 in IDLE; results match identity.
REQ-039 rst asserted during COMPUTE with 3 rows in flight -> next cycle o_c_vld=0 and o_b_loaded=0. No stale C row appears afterwards.
